// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

   // Fetch FSM encodings
   localparam logic [1:0] FETCH_BOOT  = 2'd0;
   localparam logic [1:0] FETCH_RUN   = 2'd1;
   localparam logic [1:0] FETCH_FLUSH = 2'd2;

   typedef enum logic [1:0] {
      StBoot  = FETCH_BOOT,
      StRun   = FETCH_RUN,
      StFlush = FETCH_FLUSH
   } fetch_state_e;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   // RV32I opcodes (id_instr[6:0])
   localparam logic [6:0] OPCODE_LOAD   = 7'h03;
   localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
   localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
   localparam logic [6:0] OPCODE_STORE  = 7'h23;
   localparam logic [6:0] OPCODE_OP     = 7'h33;
   localparam logic [6:0] OPCODE_LUI    = 7'h37;
   localparam logic [6:0] OPCODE_BRANCH = 7'h63;
   localparam logic [6:0] OPCODE_JALR   = 7'h67;
   localparam logic [6:0] OPCODE_JAL    = 7'h6F;

   // funct3 values (id_instr[14:12])
   localparam logic [2:0] FUNCT3_ADD = 3'b000;
   localparam logic [2:0] FUNCT3_BEQ = 3'b000;
   localparam logic [2:0] FUNCT3_BNE = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   // Clear the byte offset of a fetch address
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; used for the {instr, pc} prefetch queue and the request PC tags.
// Callers guarantee no push when full and no pop when empty.
module fetch_queue #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [Width-1:0]         data_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         data_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;

   // Pointer update; flush empties the queue and wins over push/pop
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_i) wptr_d = wptr_q + 1'b1;
         if (pop_i)  rptr_d = rptr_q + 1'b1;
      end
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage is not reset; the consumer masks the head while empty
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
   end

   assign data_o  = mem_q[rptr_q[AW-1:0]];
   assign count_o = wptr_q - rptr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, prefetch queue, redirect.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/redirect/stall performance counters.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt_o,
   output logic [31:0] perf_redirect_cnt_o,
   output logic [31:0] perf_stall_cnt_o
`endif
);

   localparam int unsigned   CntW      = $clog2(QDEPTH) + 1;
   localparam logic [CntW:0] CreditMax = (CntW + 1)'(QDEPTH);

   fetch_state_e    state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [CntW-1:0] discard_q, discard_d;
   logic [CntW-1:0] occupancy, inflight;
   logic [CntW:0]   credit_sum;
   logic [63:0]     head;
   logic [31:0]     tag_pc;
   logic            req_valid, req_fire, id_valid, push_data, pop_data;

   // Occupancy plus outstanding requests must leave room for every response
   assign credit_sum = {1'b0, occupancy} + {1'b0, inflight};
   assign req_valid  = (state_q != StBoot) & ~redirect_valid_i & (credit_sum < CreditMax);
   assign req_fire   = req_valid & imem_req_ready_i;
   assign id_valid   = (occupancy != '0) & ~redirect_valid_i;
   assign pop_data   = id_valid & id_ready_i;
   // Responses owed to a redirected-away stream (or arriving on the redirect cycle) are dropped
   assign push_data  = imem_rsp_valid_i & ~redirect_valid_i & (discard_q == '0);

   fetch_queue #(
      .Width (64),
      .Depth (QDEPTH)
   ) u_data_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid_i),
      .push_i  (push_data),
      .data_i  ({imem_rsp_data_i, tag_pc}),
      .pop_i   (pop_data),
      .data_o  (head),
      .count_o (occupancy)
   );

   // Tag count doubles as the outstanding-request counter
   fetch_queue #(
      .Width (32),
      .Depth (QDEPTH)
   ) u_tag_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (1'b0),
      .push_i  (req_fire),
      .data_i  (pc_q),
      .pop_i   (imem_rsp_valid_i),
      .data_o  (tag_pc),
      .count_o (inflight)
   );

   // Next PC, discard count and FSM state
   always_comb begin
      pc_d      = pc_q;
      discard_d = discard_q;
      state_d   = state_q;
      if (redirect_valid_i) begin
         pc_d      = word_align(redirect_pc_i);
         discard_d = inflight - CntW'(imem_rsp_valid_i);
      end else begin
         if (req_fire) pc_d = pc_q + 32'd4;
         if (imem_rsp_valid_i && discard_q != '0) discard_d = discard_q - CntW'(1);
      end
      case (state_q)
         StBoot:  state_d = StRun;
         StRun:   if (redirect_valid_i && inflight != '0) state_d = StFlush;
         StFlush: if (discard_d == '0) state_d = StRun;
         default: state_d = StBoot;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StBoot;
         pc_q      <= RESET_PC;
         discard_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
      end
   end

   assign imem_req_valid_o = req_valid;
   assign imem_req_addr_o  = req_valid ? pc_q : '0;
   assign id_valid_o       = id_valid;
   assign id_instr_o       = id_valid ? head[63:32] : '0;
   assign id_pc_o          = id_valid ? head[31:0]  : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_redirect_q, perf_stall_q;

   // Free-running event counters, wrap on overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_q    <= '0;
         perf_redirect_q <= '0;
         perf_stall_q    <= '0;
      end else begin
         if (push_data)                perf_fetch_q    <= perf_fetch_q + 32'd1;
         if (redirect_valid_i)         perf_redirect_q <= perf_redirect_q + 32'd1;
         if (id_ready_i && !id_valid)  perf_stall_q    <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetch_cnt_o    = perf_fetch_q;
   assign perf_redirect_cnt_o = perf_redirect_q;
   assign perf_stall_cnt_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order imem model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   // Depth 4 lets the credit rule sustain one instruction per cycle at single-cycle latency
   localparam int unsigned QD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        id_valid, id_ready;
   logic [31:0] id_instr, id_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int          n_checks = 0;
   int          n_errors = 0;
   int          lat = 1;
   int          cyc = 0;
   int          wcyc;
   logic        req_fire_s = 1'b0, rsp_taken_s = 1'b0;
   logic [31:0] req_addr_s = '0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] fire_q[$];

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (QD)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req_valid_o (imem_req_valid),
      .imem_req_ready_i (imem_req_ready),
      .imem_req_addr_o  (imem_req_addr),
      .imem_rsp_valid_i (imem_rsp_valid),
      .imem_rsp_data_i  (imem_rsp_data),
      .id_valid_o       (id_valid),
      .id_ready_i       (id_ready),
      .id_instr_o       (id_instr),
      .id_pc_o          (id_pc),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] imem_word(input logic [31:0] addr);
      return {addr[26:2], OPCODE_OP_IMM};
   endfunction

   function automatic logic [31:0] first_fire();
      if (fire_q.size() > 0) return fire_q[0];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   // Negedges until id_valid; cycles = index of the first negedge that sees it
   task automatic wait_id_valid(input string tag, output int cycles);
      cycles = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (id_valid) begin
            cycles = i;
            break;
         end
      end
      check_eq({tag, "_seen"}, 32'(cycles >= 0), 32'd1);
   endtask

   // Mid-cycle sampling of handshakes and of every instruction decode accepts
   always @(negedge clk) begin
      if (rst_n) begin
         req_fire_s  = imem_req_valid & imem_req_ready;
         req_addr_s  = imem_req_addr;
         rsp_taken_s = imem_rsp_valid;
         if (req_fire_s) fire_q.push_back(req_addr_s);
         if (id_valid && id_ready) check_eq("id_instr", id_instr, imem_word(id_pc));
      end else begin
         req_fire_s  = 1'b0;
         rsp_taken_s = 1'b0;
      end
   end

   // In-order imem: a request accepted at an edge answers lat cycles later
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         pend_addr.delete();
         pend_due.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else begin
         cyc++;
         if (rsp_taken_s && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         if (req_fire_s) begin
            pend_addr.push_back(req_addr_s);
            pend_due.push_back(cyc + lat - 1);
         end
         if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = imem_word(pend_addr[0]);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rst_id_valid",  32'(id_valid),       32'd0);
      check_eq("rst_req_addr",  imem_req_addr,       32'h0);
      check_eq("rst_id_instr",  id_instr,            32'h0);
      check_eq("rst_id_pc",     id_pc,               32'h0);

      // Decode stalled: BOOT, then four requests fill the credit, head holds at 0x0
      drive_edge();
      rst_n = 1'b1;
      fire_q.delete();
      @(negedge clk);
      check_eq("boot_req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      check_eq("run_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("run_req_addr",  imem_req_addr,       32'h0);
      @(negedge clk);
      check_eq("lat_id_valid_c2", 32'(id_valid), 32'd0);
      @(negedge clk);
      check_eq("lat_id_valid_c3", 32'(id_valid), 32'd1);
      check_eq("lat_id_pc_c3",    id_pc,         32'h0);
      repeat (7) @(negedge clk);
      check_eq("hold_fires",     32'(fire_q.size()),  32'(QD));
      check_eq("hold_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("hold_id_valid",  32'(id_valid),       32'd1);
      check_eq("hold_id_pc",     id_pc,               32'h0);

      // Decode ready: one instruction per cycle in program order
      drive_edge();
      id_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("stream_id_valid", 32'(id_valid), 32'd1);
         check_eq("stream_id_pc",    id_pc,         32'(k * 4));
      end

      // Redirect to 0x100 with stale responses in flight at latency 3
      drive_edge();
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pend_addr.size() >= 2) begin
            found = 1'b1;
            break;
         end
      end
      check_eq("redir100_outstanding", 32'(found), 32'd1);
      drive_edge();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      fire_q.delete();
      @(negedge clk);
      check_eq("redir_cycle_id_valid",  32'(id_valid),       32'd0);
      check_eq("redir_cycle_req_valid", 32'(imem_req_valid), 32'd0);
      drive_edge();
      redirect_valid = 1'b0;
      wait_id_valid("redir100", wcyc);
      check_eq("redir100_id_pc",     id_pc,        32'h0000_0100);
      check_eq("redir100_first_req", first_fire(), 32'h0000_0100);

      // Misaligned redirect target is word aligned
      drive_edge();
      lat            = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      fire_q.delete();
      drive_edge();
      redirect_valid = 1'b0;
      wait_id_valid("redir203", wcyc);
      check_eq("redir203_id_pc",     id_pc,        32'h0000_0200);
      check_eq("redir203_first_req", first_fire(), 32'h0000_0200);

      // Back-to-back redirects: the first target is never fetched
      drive_edge();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      fire_q.delete();
      drive_edge();
      redirect_pc    = 32'h0000_0080;
      drive_edge();
      redirect_valid = 1'b0;
      wait_id_valid("redir80", wcyc);
      check_eq("redir80_id_pc",     id_pc,        32'h0000_0080);
      check_eq("redir80_first_req", first_fire(), 32'h0000_0080);

      // Reset pulse mid-stream
      repeat (3) @(negedge clk);
      check_eq("pre_rst_id_valid", 32'(id_valid), 32'd1);
      drive_edge();
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_id_valid",  32'(id_valid),       32'd0);
      check_eq("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("mid_rst_id_pc",     id_pc,               32'h0);
      repeat (2) @(negedge clk);
      drive_edge();
      fire_q.delete();
      rst_n = 1'b1;
      wait_id_valid("refetch", wcyc);
      check_eq("refetch_latency",   32'(wcyc),    32'd3);
      check_eq("refetch_id_pc",     id_pc,        32'h0);
      check_eq("refetch_first_req", first_fire(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
